// File: rtl/serial_adder_pkg.sv
// Shared types and default sizes for the bit-serial adder.
//   state_t : FSM encoding used by serial_adder4
//   WIDTH   : default operand width (result is WIDTH+1 bits)
//   CNT_W   : default width of the completed-operation counter
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

endpackage

// File: rtl/serial_adder4_fa1.sv
// Combinational 1-bit full adder, the single arithmetic cell of the serial datapath.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module fa1 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder4.sv
// Bit-serial handshaked adder: accepts one a/b pair, adds LSB-first one bit per
// clock through a single full adder, and presents the WIDTH+1-bit sum.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand channel (a, b)
//   out_valid / out_ready: result channel (result)
//   op_count             : results handed off, wraps modulo 2^CNT_W
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// ADD   | one result bit per clock, WIDTH clocks
// DONE  | result valid, held until out_ready
module serial_adder4 #(
   parameter int WIDTH = serial_adder_pkg::WIDTH,
   parameter int CNT_W = serial_adder_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic [CNT_W-1:0] op_count
);

   import serial_adder_pkg::*;

   localparam int BC_W = $clog2(WIDTH + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

   state_t            state;
   logic [WIDTH-1:0]  a_sh;
   logic [WIDTH-1:0]  b_sh;
   logic              carry;
   logic [BC_W-1:0]   bit_cnt;
   logic              sum_s;
   logic              sum_cout;

   fa1 u_fa1 (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (sum_s),
      .cout (sum_cout)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         carry    <= 1'b0;
         bit_cnt  <= '0;
         result   <= '0;
         op_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry   <= 1'b0;
                  bit_cnt <= '0;
                  state   <= ADD;
               end
            end
            ADD: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               carry   <= sum_cout;
               // Sum bits enter at the top so the first bit lands in bit 0 after WIDTH shifts.
               result[WIDTH-1:0] <= {sum_s, result[WIDTH-1:1]};
               bit_cnt <= bit_cnt + BC_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  result[WIDTH] <= sum_cout;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  op_count <= op_count + CNT_W'(1);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder4.sv
module tb_serial_adder4;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] result;
   logic [7:0] op_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_ops = 0;
   int accept_cyc = 0;

   typedef struct {
      int a;
      int b;
      int exp;
   } vec_t;

   vec_t vecs[4];

   serial_adder4 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready, then presents a/b for exactly one accept edge.
   task automatic accept(input int aa, input int bb);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("in_ready_before_accept", int'(in_ready), 1);
      a = 4'(aa);
      b = 4'(bb);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      in_valid = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #23;
      rst_n = 1'b1;
      exp_ops = 0;
      tick();
   endtask

   initial begin
      int lat;
      int prev_acc;
      int held_cnt;
      int sa, sb;

      vecs[0] = '{0, 0, 0};
      vecs[1] = '{1, 1, 2};
      vecs[2] = '{15, 15, 30};
      vecs[3] = '{7, 8, 15};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      #12;
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_result", int'(result), 0);
      check("reset_op_count", int'(op_count), 0);
      do_reset();

      // Directed table with out_ready held high.
      for (int i = 0; i < 4; i++) begin
         accept(vecs[i].a, vecs[i].b);
         wait_valid(lat);
         check($sformatf("tbl%0d_latency", i), lat, 4);
         check($sformatf("tbl%0d_result", i), int'(result), vecs[i].exp);
         tick();
         exp_ops++;
         check($sformatf("tbl%0d_done_one_cycle", i), int'(out_valid), 0);
         check($sformatf("tbl%0d_op_count", i), int'(op_count), exp_ops % 256);
      end

      // Backpressure: result held in DONE while out_ready is low.
      out_ready = 1'b0;
      accept(9, 6);
      wait_valid(lat);
      check("bp_latency", lat, 4);
      held_cnt = exp_ops % 256;
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_result", int'(result), 15);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_op_count", int'(op_count), held_cnt);
         tick();
      end
      out_ready = 1'b1;
      tick();
      exp_ops++;
      check("bp_handoff_out_valid", int'(out_valid), 0);
      check("bp_handoff_op_count", int'(op_count), exp_ops % 256);

      // in_valid during ADD must be ignored.
      accept(3, 4);
      in_valid = 1'b1;
      a = 4'd15;
      b = 4'd15;
      tick();
      tick();
      in_valid = 1'b0;
      wait_valid(lat);
      check("busy_latency", lat + 2, 4);
      check("busy_result", int'(result), 7);
      tick();
      exp_ops++;
      for (int i = 0; i < 6; i++) begin
         check("busy_no_second_result", int'(out_valid), 0);
         tick();
      end
      check("busy_op_count", int'(op_count), exp_ops % 256);

      // Asynchronous reset in the middle of ADD.
      accept(12, 5);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready", int'(in_ready), 1);
      check("rst_mid_out_valid", int'(out_valid), 0);
      check("rst_mid_result", int'(result), 0);
      check("rst_mid_op_count", int'(op_count), 0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      exp_ops = 0;
      tick();
      check("rst_release_in_ready", int'(in_ready), 1);
      accept(2, 2);
      wait_valid(lat);
      check("rst_after_result", int'(result), 4);
      tick();
      exp_ops++;
      check("rst_after_op_count", int'(op_count), 1);

      // 256 back-to-back random operations: reference is plain a+b.
      do_reset();
      prev_acc = 0;
      for (int i = 0; i < 256; i++) begin
         sa = int'($urandom_range(0, 15));
         sb = int'($urandom_range(0, 15));
         accept(sa, sb);
         if (i > 0) check("wrap_period", accept_cyc - prev_acc, 6);
         prev_acc = accept_cyc;
         wait_valid(lat);
         check("wrap_latency", lat, 4);
         check("wrap_result", int'(result), sa + sb);
         tick();
         exp_ops++;
         check("wrap_op_count", int'(op_count), exp_ops % 256);
      end
      check("wrap_final_zero", int'(op_count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_adder4.md
# serial_adder4

Bit-serial, handshaked 4-bit adder: the device-side responder for the operand/result traffic our adder benches generate. It accepts one operand pair through a valid/ready input channel and adds it LSB-first, one bit per clock. It returns the WIDTH+1-bit sum through a valid/ready output channel. It replaces the single-cycle combinational adder wherever area matters more than latency, and presents the same a/b/result semantics behind a handshake.

## Interface
- WIDTH, 4: operand width in bits; result is WIDTH+1 bits.
- CNT_W, 8: width of the completed-operation counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH+1  unsigned a+b; bit WIDTH is the carry out.
- op_count  output  CNT_W  number of results handed off, modulo 2^CNT_W.

## Operation
- FSM states: IDLE, ADD, DONE. Reset state is IDLE.
- in_ready = (state==IDLE), driven combinationally from the state register. out_valid = (state==DONE), driven from the state register.
- IDLE: when in_valid && in_ready at an edge:
  - latch a and b into shift registers;
  - clear carry and bit counter;
  - go to ADD.
- ADD: every edge computes sum = a_sh[0]^b_sh[0]^carry and carry = majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by one.
  - Shift sum into result bit WIDTH-1 from the top, so result[WIDTH-1:0] fills LSB-first.
  - Increment the counter.
- On the WIDTH-th ADD edge, write result[WIDTH] = final carry, go to DONE.
- DONE: result is held stable while out_valid is high.
  - On an out_valid && out_ready edge: go to IDLE and increment op_count.
  - op_count wraps from 2^CNT_W-1 to 0.
- in_valid while not in IDLE is ignored; a/b may change freely outside the accept edge.
- Arithmetic is unsigned, with no overflow: the maximum is (2^WIDTH-1)*2, which fits in WIDTH+1 bits.

## Timing
- Reset values, applied asynchronously on rst_n low:
  - state=IDLE, so in_ready=1;
  - out_valid=0, result=0, op_count=0;
  - shift registers, carry and counter all 0.
- Deassertion of rst_n is assumed synchronized upstream; the block samples normally on the first clk edge after release.
- Latency: accept at edge E0. out_valid rises after edge E0+WIDTH, which is 4 cycles for the default WIDTH.
- Back-to-back throughput:
  - the handoff edge returns the FSM to IDLE;
  - the next accept can occur on the following edge;
  - minimum period is WIDTH+2 cycles per operation.
- out_ready held high is permitted: DONE lasts exactly one cycle.
- out_ready low stalls indefinitely in DONE; result, out_valid and op_count stay constant.
- During the ADD cycles, result bits are intermediate and undefined to the consumer; only the value under out_valid is meaningful.
- Reset mid-ADD or mid-DONE: the in-flight operation is discarded and op_count is not incremented. On release the FSM is in IDLE with in_ready=1.

## Structure
- Package serial_adder_pkg holds:
  - typedef enum state_t {IDLE, ADD, DONE};
  - localparam defaults WIDTH=4 and CNT_W=8.
- One sub-module: fa1, a combinational 1-bit full adder (a, b, cin -> s, cout), instantiated once in the datapath.
- Everything else (shift registers, counter, FSM) lives in serial_adder4.

## Test plan
- After reset release, with out_ready=1:
  - 0+0 -> result 0;
  - 1+1 -> 2;
  - 15+15 -> 30;
  - 7+8 -> 15.
  - Each out_valid appears exactly 4 cycles after its accept edge.
- Backpressure: 9+6 with out_ready=0 for 10 cycles.
  - out_valid stays 1, result stays 15, in_ready stays 0, op_count unchanged.
  - Raising out_ready gives handoff on the next edge and op_count +1.
- Busy ignore: accept 3+4, then drive in_valid=1 with a=15, b=15 during ADD.
  - result is 7; no second result appears until a new IDLE accept.
- Reset mid-ADD: accept 12+5, pull rst_n low two cycles later.
  - Outputs go to reset values immediately (asynchronous).
  - After release, 2+2 returns 4 and op_count is 1.
- Wrap: run 256 back-to-back operations with random a/b, checked against a+b.
  - op_count returns to 0 at the 256th handoff.
  - Measured period is 6 cycles per operation.
